// File: rtl/es_string_store_engine.sv
// es_string_store_engine: memory side of STOSB/STOSW (optionally REP), writing AL/AX to ES:DI
// and returning updated DI/CX through one-cycle write strobes.
module es_string_store_engine #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word,
  input  logic        rep,
  input  logic        df,
  input  logic        irq_pend,
  input  logic [15:0] es_q,
  input  logic [15:0] di_in,
  input  logic [15:0] cx_in,
  input  logic [15:0] ax_in,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic [15:0] di_out,
  output logic        di_we,
  output logic [15:0] cx_out,
  output logic        cx_we,
  output logic        busy,
  output logic        done,
  output logic        susp,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, CHECK, REQ_LO, REQ_HI, UPDATE, FINISH} state_t;
  state_t      state;
  logic [15:0] es, di, cx, ax;
  logic        w, d, r;
  logic [7:0]  tmo;
  logic [15:0] step, di_nx, lo_wdata;
  logic [19:0] addr_lo, addr_hi;
  logic [1:0]  lo_be;
  logic        ack, tmo_hit, stop;
  assign step     = w ? 16'd2 : 16'd1;
  assign di_nx    = d ? di - step : di + step;
  assign addr_lo  = {es, 4'h0} + {4'h0, di};
  assign addr_hi  = {es, 4'h0} + {4'h0, di + 16'd1};
  assign lo_wdata = (w && !di[0]) ? ax : {ax[7:0], ax[7:0]};
  assign lo_be    = (w && !di[0]) ? 2'b11 : di[0] ? 2'b10 : 2'b01;
  assign ack      = mem_req && mem_ack;
  assign tmo_hit  = tmo == 8'(BUS_TIMEOUT - 1);
  // CHECK only skips on REP with CX=0; UPDATE continues only while REP, CX!=0 and no IRQ
  assign stop     = (state == CHECK) ? (r && cx == 16'd0) : !(r && cx != 16'd0 && !irq_pend);
  assign di_out   = di;
  assign cx_out   = cx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      es        <= '0;
      di        <= '0;
      cx        <= '0;
      ax        <= '0;
      w         <= 1'b0;
      d         <= 1'b0;
      r         <= 1'b0;
      tmo       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      di_we     <= 1'b0;
      cx_we     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      susp      <= 1'b0;
      err       <= 1'b0;
    end else begin
      di_we <= 1'b0;
      cx_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          es    <= es_q;
          di    <= di_in;
          cx    <= cx_in;
          ax    <= ax_in;
          w     <= word;
          d     <= df;
          r     <= rep;
          busy  <= 1'b1;
          susp  <= 1'b0;
          state <= CHECK;
        end
        CHECK, UPDATE: if (stop) begin
          done  <= 1'b1;
          susp  <= r && cx != 16'd0;
          state <= FINISH;
        end else begin
          mem_req   <= 1'b1;
          mem_addr  <= addr_lo;
          mem_wdata <= lo_wdata;
          mem_be    <= lo_be;
          tmo       <= '0;
          state     <= REQ_LO;
        end
        REQ_LO, REQ_HI: if (ack) begin
          tmo <= '0;
          if (state == REQ_LO && w && di[0]) begin
            mem_addr  <= addr_hi;
            mem_wdata <= {ax[15:8], ax[15:8]};
            mem_be    <= 2'b01;
            state     <= REQ_HI;
          end else begin
            mem_req <= 1'b0;
            di      <= di_nx;
            di_we   <= 1'b1;
            cx      <= r ? cx - 16'd1 : cx;
            cx_we   <= r;
            state   <= UPDATE;
          end
        end else if (tmo_hit) begin
          mem_req <= 1'b0;
          err     <= 1'b1;
          busy    <= 1'b0;
          tmo     <= '0;
          state   <= IDLE;
        end else begin
          tmo <= tmo + 8'd1;
        end
        FINISH: begin
          busy  <= 1'b0;
          susp  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
